iec_line_filter: RTL

- Parametrised multi-channel successor to the single-bit 2-flop synchroniser/deglitcher used on the IEC inputs of the drive models.
- Synchronises N asynchronous bus lines (ATN/CLK/DATA/FCLK/RESET, parallel strobe).
- Per channel: runtime-programmable deglitch filter, clock-enable gating for pause, 1-cycle rise/fall strobes, sticky maskable event flags and an aggregated active-low interrupt.
- Sits between drive top-level pins and CIA/VIA/CPU logic.

---
 rtl/iec_filter_pkg.sv | 14 +
 rtl/iec_filter_chan.sv | 89 ++++++++
 rtl/iec_line_filter.sv | 49 ++++
 3 files changed

// File: rtl/iec_filter_pkg.sv
// Shared constants for the IEC line filter: default geometry and the channel
// indices that drive top-levels use to pick lines out of the filter vectors.
package iec_filter_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILTER_BITS = 3;
  localparam logic        DEF_RESET_LEVEL = 1'b1;

  localparam int unsigned CH_ATN  = 0;
  localparam int unsigned CH_CLK  = 1;
  localparam int unsigned CH_DATA = 2;
  localparam int unsigned CH_FCLK = 3;

endpackage

// File: rtl/iec_filter_chan.sv
// One IEC input line: synchroniser chain, ce-gated deglitch counter, filtered
// level, registered rise/fall strobes and a sticky maskable event flag.
module iec_filter_chan
  import iec_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_BITS = DEF_FILTER_BITS,
  parameter logic        RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   ce_i,
  input  logic [FILTER_BITS-1:0] filt_len_i,
  input  logic                   in_i,
  output logic                   out_o,
  output logic                   rise_o,
  output logic                   fall_o,
  input  logic                   evt_rise_en_i,
  input  logic                   evt_fall_en_i,
  input  logic                   evt_clr_i,
  output logic                   evt_pend_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTER_BITS-1:0] cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   out_dly_q;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   pend_q, pend_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    cnt_d  = cnt_q;
    out_d  = out_q;
    // Threshold compare uses the live filt_len so a reprogram takes effect at once.
    if (ce_i) begin
      if (sync_s == out_q) begin
        cnt_d = '0;
      end else if (cnt_q >= filt_len_i) begin
        out_d = sync_s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + FILTER_BITS'(1);
      end
    end

    rise_d = out_q & ~out_dly_q;
    fall_d = ~out_q & out_dly_q;

    // A new event beats a simultaneous clear.
    if ((rise_q & evt_rise_en_i) | (fall_q & evt_fall_en_i)) begin
      pend_d = 1'b1;
    end else if (evt_clr_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q     <= '0;
      out_q     <= RESET_LEVEL;
      out_dly_q <= RESET_LEVEL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_dly_q <= out_q;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pend_q    <= pend_d;
    end
  end

  assign out_o      = out_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign evt_pend_o = pend_q;

endmodule

// File: rtl/iec_line_filter.sv
// Multi-channel IEC input conditioner: independent per-line filters with an
// aggregated active-low interrupt built only from the pend registers.
module iec_line_filter
  import iec_filter_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_BITS = DEF_FILTER_BITS,
  parameter logic        RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   ce_i,
  input  logic [FILTER_BITS-1:0] filt_len_i,
  input  logic [CHANNELS-1:0]    in_i,
  output logic [CHANNELS-1:0]    out_o,
  output logic [CHANNELS-1:0]    rise_o,
  output logic [CHANNELS-1:0]    fall_o,
  input  logic [CHANNELS-1:0]    evt_rise_en_i,
  input  logic [CHANNELS-1:0]    evt_fall_en_i,
  input  logic [CHANNELS-1:0]    evt_clr_i,
  output logic [CHANNELS-1:0]    evt_pend_o,
  output logic                   irq_no
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    iec_filter_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_BITS (FILTER_BITS),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .ce_i          (ce_i),
      .filt_len_i    (filt_len_i),
      .in_i          (in_i[g]),
      .out_o         (out_o[g]),
      .rise_o        (rise_o[g]),
      .fall_o        (fall_o[g]),
      .evt_rise_en_i (evt_rise_en_i[g]),
      .evt_fall_en_i (evt_fall_en_i[g]),
      .evt_clr_i     (evt_clr_i[g]),
      .evt_pend_o    (evt_pend_o[g])
    );
  end

  assign irq_no = ~|evt_pend_o;

endmodule
